// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit in front of a 64-bit data memory.
// Loads take one memory read. Stores do a read-modify-write of the whole
// doubleword: two aligned word reads, then one full-doubleword write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses return rsp_err=1 without touching memory. When
// undefined, the low address bits are cleared and the access goes ahead.
module load_store_unit #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [63:0]       mem_rd_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic              mem_wr_en
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, RD_LO, RD_HI, WR, RESP} state_t;

    state_t            state, state_next;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [63:0]       dword_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_err_q;

    logic              legal, misaligned, reject;
    logic [ADDR_W-1:0] req_addr_al;
    logic [31:0]       load_shifted, load_ext;
    logic [7:0]        size_mask, byte_mask;
    logic [63:0]       wdata_sh, merged;
    logic              unused_addr_hi;

    // Only the low ADDR_W address bits reach the memory.
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    // Classify the incoming request and derive its aligned address.
    always_comb begin
        if (req_we) legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else        legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        reject      = !legal || (TRAP_MISALIGN && misaligned);
        req_addr_al = req_addr[ADDR_W-1:0];
        if (req_funct3[1:0] == 2'b01) req_addr_al[0]   = 1'b0;
        if (req_funct3[1:0] == 2'b10) req_addr_al[1:0] = 2'b00;
    end

    // Load path: shift the selected lane down and extend by funct3.
    always_comb begin
        load_shifted = 32'(mem_rd_data >> {addr_q[2:0], 3'b000});
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_ext = {24'b0, load_shifted[7:0]};
            3'b101:  load_ext = {16'b0, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Store path: replace bytes [off, off+size) of the read doubleword.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
        byte_mask = size_mask << addr_q[2:0];
        wdata_sh  = {32'b0, wdata_q} << {addr_q[2:0], 3'b000};
        for (int b = 0; b < 8; b++)
            merged[b*8 +: 8] = byte_mask[b] ? wdata_sh[b*8 +: 8] : dword_q[b*8 +: 8];
    end

    // Next-state and memory-port decode.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        mem_rd_addr = '0;
        mem_funct3  = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: if (req_valid) begin
                if (reject)      state_next = RESP;
                else if (req_we) state_next = RD_LO;
                else             state_next = LOAD;
            end
            LOAD: begin
                mem_rd_addr = addr_q;
                mem_funct3  = {1'b0, funct3_q[1:0]};
                state_next  = RESP;
            end
            RD_LO: begin
                mem_rd_addr = {addr_q[ADDR_W-1:3], 3'b000};
                mem_funct3  = 3'b010;
                state_next  = RD_HI;
            end
            RD_HI: begin
                mem_rd_addr = {addr_q[ADDR_W-1:3], 3'b100};
                mem_funct3  = 3'b010;
                state_next  = WR;
            end
            WR: begin
                // Gated by reset so an abandoned store never reaches memory.
                mem_wr_en   = !reset;
                mem_wr_addr = {addr_q[ADDR_W-1:3], 3'b000};
                mem_wr_data = merged;
                state_next  = RESP;
            end
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // State register, request capture and datapath registers.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dword_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    funct3_q   <= req_funct3;
                    addr_q     <= req_addr_al;
                    wdata_q    <= req_wdata;
                    dword_q    <= '0;
                    rsp_data_q <= '0;
                    rsp_err_q  <= reject;
                end
                LOAD:    rsp_data_q <= load_ext;
                RD_LO:   dword_q    <= mem_rd_data;
                RD_HI:   dword_q    <= dword_q | mem_rd_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a behavioural
// 64-bit memory. Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_data;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [63:0]       mem_rd_data, mem_wr_data;
    logic              mem_wr_en;

    logic [63:0] mem [0:4095];

    int n_pass = 0;
    int n_total = 0;

    // Results of the last transaction.
    logic [31:0]       r_data;
    logic              r_err;
    int                r_lat, r_wr_cnt, r_wr_lat, r_rd_cnt, r_busy_ready;
    logic [ADDR_W-1:0] r_wr_addr;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .mem_funct3(mem_funct3), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
    );

    always #5 clk = ~clk;

    // Memory read: selected bytes in their lanes, other lanes zero.
    always_comb begin
        int off, sz;
        off = int'(mem_rd_addr[2:0]);
        sz  = (mem_funct3[1:0] == 2'b00) ? 1 : (mem_funct3[1:0] == 2'b01) ? 2 : 4;
        mem_rd_data = '0;
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + sz)
                mem_rd_data[b*8 +: 8] = mem[mem_rd_addr[ADDR_W-1:3]][b*8 +: 8];
    end

    always @(posedge clk)
        if (mem_wr_en) mem[mem_wr_addr[ADDR_W-1:3]] <= mem_wr_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request, wait for the response (bounded), optionally hold
    // rsp_ready low for `hold` cycles checking rsp_data against hold_exp.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input logic [31:0] hold_exp);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 0; r_wr_cnt = 0; r_wr_lat = 0; r_rd_cnt = 0; r_busy_ready = 0; r_wr_addr = '0;
        while (r_lat < 20) begin
            @(negedge clk);
            r_lat++;
            // Requests while busy must be ignored; keep one asserted to prove it.
            req_valid = 1'b1;
            if (mem_wr_en) begin r_wr_cnt++; r_wr_lat = r_lat; r_wr_addr = mem_wr_addr; end
            if (mem_rd_addr != '0) r_rd_cnt++;
            if (rsp_valid) break;
            if (req_ready) r_busy_ready++;
        end
        req_valid = 1'b0;
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        r_data = rsp_data;
        r_err  = rsp_err;
        check("resp_rd_port_idle", {mem_rd_addr, mem_funct3}, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, hold_exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        do_req(1'b0, f3, addr, 32'h0, 0, 32'h0);
        check({tag, "_data"}, r_data, exp);
        check({tag, "_err"}, r_err, 0);
        check({tag, "_lat"}, r_lat, 2);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [11:0] idx, input logic [63:0] exp);
        do_req(1'b1, f3, addr, wdata, 0, 32'h0);
        check({tag, "_wr_cnt"}, r_wr_cnt, 1);
        check({tag, "_wr_lat"}, r_wr_lat, 3);
        check({tag, "_wr_addr"}, r_wr_addr, {idx, 3'b000});
        check({tag, "_lat"}, r_lat, 4);
        check({tag, "_err"}, r_err, 0);
        check({tag, "_data"}, r_data, 0);
        check({tag, "_mem"}, mem[idx], exp);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[2] = 64'h8877665544332211;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_wr_en", mem_wr_en, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        // Loads from doubleword 0x10.
        load_chk("lb_17",  3'b000, 32'h17, 32'hFFFFFF88);
        load_chk("lbu_17", 3'b100, 32'h17, 32'h00000088);
        load_chk("lb_10",  3'b000, 32'h10, 32'h00000011);
        load_chk("lh_16",  3'b001, 32'h16, 32'hFFFF8877);
        load_chk("lhu_12", 3'b101, 32'h12, 32'h00004433);
        load_chk("lw_14",  3'b010, 32'hFFFF0014, 32'h88776655);
        check("busy_ready", r_busy_ready, 0);

        // Misaligned word load.
        do_req(1'b0, 3'b010, 32'h13, 32'h0, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_13_err", r_err, 1);
        check("lw_13_data", r_data, 0);
        check("lw_13_lat", r_lat, 1);
        check("lw_13_reads", r_rd_cnt, 0);
`else
        check("lw_13_err", r_err, 0);
        check("lw_13_data", r_data, 32'h44332211);
        check("lw_13_lat", r_lat, 2);
        check("lw_13_reads", r_rd_cnt, 1);
`endif

        // Illegal funct3 for load and store.
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0);
        check("ill_ld_err", r_err, 1);
        check("ill_ld_data", r_data, 0);
        check("ill_ld_lat", r_lat, 1);
        check("ill_ld_wr", r_wr_cnt, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'h1234, 0, 32'h0);
        check("ill_st_err", r_err, 1);
        check("ill_st_wr", r_wr_cnt, 0);
        check("ill_st_mem", mem[2], 64'h8877665544332211);

        // Stores (read-modify-write).
        store_chk("sh_12", 3'b001, 32'h12, 32'h0000BEEF, 12'd2, 64'h88776655BEEF2211);
        store_chk("sb_17", 3'b000, 32'h17, 32'h123456AA, 12'd2, 64'hAA776655BEEF2211);
        store_chk("sw_18", 3'b010, 32'h18, 32'hDEADBEEF, 12'd3, 64'h00000000DEADBEEF);
        store_chk("sw_1c", 3'b010, 32'h1C, 32'h12345678, 12'd3, 64'h12345678DEADBEEF);
        load_chk("lb_1f", 3'b000, 32'h1F, 32'h00000012);

        // Response held while rsp_ready stays low for 5 cycles.
        do_req(1'b0, 3'b010, 32'h1C, 32'h0, 5, 32'h12345678);
        check("hold_lw_data", r_data, 32'h12345678);

        // Reset during RD_HI abandons the store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        r_wr_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr_en) r_wr_cnt++;
        end
        check("rst_rdhi_valid", rsp_valid, 0);
        check("rst_rdhi_ready", req_ready, 0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en) r_wr_cnt++;
        end
        check("rst_rdhi_wr", r_wr_cnt, 0);
        check("rst_rdhi_ready_after", req_ready, 1);
        check("rst_rdhi_valid_after", rsp_valid, 0);
        check("rst_rdhi_mem", mem[4], 0);

        // Reset during WR gates mem_wr_en combinationally.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h28; req_wdata = 32'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_state_en", mem_wr_en, 1);
        reset = 1'b1;
        #1;
        check("rst_wr_gated", mem_wr_en, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_mem", mem[5], 0);
        check("rst_wr_valid", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, byte-address width of the 64-bit data memory (4096 doublewords).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  execute stage presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts an access; high only in IDLE.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I load/store funct3.
REQ-008 SHALL have port req_addr  input  32  byte address; bits above ADDR_W-1 ignored.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  writeback stage consumes result.
REQ-012 SHALL have port rsp_data  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  illegal funct3 or trapped misalignment.
REQ-014 SHALL have port mem_funct3  output  3  funct3 driven to the data memory.
REQ-015 SHALL have port mem_rd_addr  output  ADDR_W  memory read byte address.
REQ-016 SHALL have port mem_rd_data  input  64  memory async read data; selected bytes appear in their doubleword lane, other lanes zero.
REQ-017 SHALL have port mem_wr_addr / mem_wr_data / mem_wr_en  output  ADDR_W / 64 / 1  full-doubleword write port.

Function
REQ-018 SHALL register the request (we, funct3, addr, wdata) when req_valid && req_ready; FSM states IDLE, LOAD, RD_LO, RD_HI, WR, RESP.
REQ-019 SHALL classify: loads legal funct3 000/001/010/100/101, stores 000/001/010; any other value -> RESP with rsp_err=1, no memory access.
REQ-020 SHALL treat halfword with addr[0]=1 and word with addr[1:0]!=0 as misaligned (handling per REQ-031/032).
REQ-021 Load, accept cycle T: LOAD at T+1 drives mem_rd_addr=addr, mem_funct3={0,funct3[1:0]}, captures mem_rd_data >> (addr[2:0]*8), sign-extends (000/001) or zero-extends (100/101); RESP at T+2.
REQ-022 Store (read-modify-write, memory writes all 8 bytes): RD_LO at T+1 reads {addr[ADDR_W-1:3],3'b000} with mem_funct3=010; RD_HI at T+2 reads base+4; OR both into doubleword D.
REQ-023 WR at T+3 SHALL drive mem_wr_en=1 for exactly one cycle, mem_wr_addr=base, mem_wr_data = D with bytes [off, off+size) replaced by req_wdata bytes, off=addr[2:0]; RESP at T+4.
REQ-024 In RESP rsp_valid SHALL stay high with stable rsp_data/rsp_err until rsp_ready; handshake cycle returns to IDLE; next req accepted one cycle later.
REQ-025 mem_wr_en SHALL be 0 outside WR and SHALL be forced 0 combinationally while reset is high.
REQ-026 Outside LOAD/RD_LO/RD_HI, mem_rd_addr and mem_funct3 SHALL be 0.
REQ-027 A request during non-IDLE states SHALL be ignored (req_ready=0); req fields may change freely.

Reset
REQ-028 Reset high at any edge SHALL force IDLE, abandoning any in-flight access with no memory write and no response.
REQ-029 Reset values: req_ready=0 during reset then 1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_wr_en=0, internal registers 0.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-031 Defined: misaligned access skips memory, goes IDLE->RESP (rsp_valid at T+1), rsp_err=1, rsp_data=0.
REQ-032 Undefined: address low bits forced to alignment (halfword clear bit0, word clear bits1:0), access performed normally, rsp_err=0.

Verification
REQ-033 Mem doubleword at 0x10 = 0x8877665544332211; LB addr 0x17 -> rsp_data 0xFFFFFF88 at T+2; LBU -> 0x00000088.
REQ-034 Same memory; SH addr 0x12 wdata 0x0000BEEF -> one mem_wr_en pulse at T+3, wr_addr 0x10, wr_data 0x88776655BEEF2211, rsp at T+4 err=0.
REQ-035 LW addr 0x13: with macro -> rsp_err=1 at T+1, no mem read; without -> reads 0x10, rsp_data 0x44332211, err=0.
REQ-036 Load funct3=011 -> rsp_err=1, rsp_data 0, mem_wr_en never high.
REQ-037 Store, reset asserted in RD_HI cycle -> no mem_wr_en pulse, rsp_valid 0, req_ready 1 after reset drops; rsp_ready held low 5 cycles on a load -> rsp_data stable throughout.
